// File: rtl/sync_counter_ctrl.sv
// -----------------------------------------------------------------------------
// sync_counter_ctrl
//   Sequencer for a WIDTH-bit synchronous counter built from a bank of T
//   flip-flops. The bank's state comes back on q_in; this block decides, every
//   cycle, which flip-flops toggle (t_out) so the bank counts up or down, stops
//   at or reloads from a terminal count, or jumps straight to a load value.
//
//   Optional feature macro: SYNC_CNT_PRESCALE_EN
//     defined     -> a step only happens every PRESCALE-th RUN cycle
//     not defined -> every RUN cycle is a step cycle (PRESCALE unused)
//
// Ports
//   clk          rising-edge clock shared with the T-FF bank
//   rst          synchronous active-high reset (does not clear the bank)
//   start        pulse: begin/resume counting (ignored while already running)
//   stop         pulse: RUN->HOLD, HOLD/DONE->IDLE
//   load         pulse: make the bank equal load_val on the next cycle
//   load_val     value for load
//   dir          1=up, 0=down, captured when start is accepted
//   auto_reload  1=periodic, 0=one-shot, captured when start is accepted
//   limit        up: terminal value, down: reload value
//   q_in         current T-FF bank outputs
//   t_out        toggle enables to the bank (combinational)
//   busy         registered, 1 in RUN or HOLD
//   done         registered, 1 in DONE
//   tc_pulse     registered one-cycle pulse after a terminal-count step
// -----------------------------------------------------------------------------
module sync_counter_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] t_out,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bit i toggles when all lower bits are 1 (increment carry chain).
    function automatic logic [WIDTH-1:0] up_toggles(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] t;
        logic             carry;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]  = carry;
            carry = carry & q[i];
        end
        return t;
    endfunction

    // Bit i toggles when all lower bits are 0 (decrement borrow chain).
    function automatic logic [WIDTH-1:0] down_toggles(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] t;
        logic             borrow;
        borrow = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]   = borrow;
            borrow = borrow & ~q[i];
        end
        return t;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic             dir_r;
    logic             dir_next_s;
    logic             reload_r;
    logic             reload_next_s;
    logic             busy_r;
    logic             done_r;
    logic             tc_r;
    logic             tc_next_s;
    logic             step_s;
    logic             term_s;
    logic             start_ok_s;
    logic [WIDTH-1:0] t_out_s;

    assign start_ok_s = start && (state_r != ST_RUN);
    assign term_s     = dir_r ? (q_in == limit) : (q_in == {WIDTH{1'b0}});

`ifdef SYNC_CNT_PRESCALE_EN
    localparam int              PW      = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_r;

    assign step_s = (state_r == ST_RUN) && (presc_r == PS_LAST);

    // Prescale phase: restarts on reset/load/start, frozen outside RUN and on stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= {PW{1'b0}};
        end else if (load) begin
            presc_r <= {PW{1'b0}};
        end else if (stop) begin
            presc_r <= presc_r;
        end else if (start_ok_s) begin
            presc_r <= {PW{1'b0}};
        end else if (state_r == ST_RUN) begin
            presc_r <= (presc_r == PS_LAST) ? {PW{1'b0}} : presc_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            presc_r <= presc_r;
        end
    end
`else
    assign step_s = (state_r == ST_RUN);
`endif

    // Next-state, mode capture, toggle enables and terminal pulse, in command priority order.
    always_comb begin
        state_next_s  = state_r;
        dir_next_s    = dir_r;
        reload_next_s = reload_r;
        tc_next_s     = 1'b0;
        t_out_s       = {WIDTH{1'b0}};
        if (rst) begin
            state_next_s  = ST_IDLE;
            dir_next_s    = 1'b1;
            reload_next_s = 1'b0;
        end else if (load) begin
            // Toggle exactly the bits that differ from the target value.
            t_out_s = q_in ^ load_val;
            if (state_r == ST_DONE) begin
                state_next_s = ST_IDLE;
            end else begin
                state_next_s = state_r;
            end
        end else if (stop) begin
            case (state_r)
                ST_RUN:  state_next_s = ST_HOLD;
                ST_HOLD: state_next_s = ST_IDLE;
                ST_DONE: state_next_s = ST_IDLE;
                default: state_next_s = state_r;
            endcase
        end else if (start_ok_s) begin
            state_next_s  = ST_RUN;
            dir_next_s    = dir;
            reload_next_s = auto_reload;
        end else if (step_s) begin
            if (term_s) begin
                tc_next_s = 1'b1;
                if (reload_r) begin
                    // Up wraps to zero, down reloads from limit.
                    t_out_s = q_in ^ (dir_r ? {WIDTH{1'b0}} : limit);
                end else begin
                    state_next_s = ST_DONE;
                end
            end else if (dir_r) begin
                t_out_s = up_toggles(q_in);
            end else begin
                t_out_s = down_toggles(q_in);
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // State, captured mode and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            dir_r    <= 1'b1;
            reload_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            tc_r     <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            dir_r    <= dir_next_s;
            reload_r <= reload_next_s;
            busy_r   <= (state_next_s == ST_RUN) || (state_next_s == ST_HOLD);
            done_r   <= (state_next_s == ST_DONE);
            tc_r     <= tc_next_s;
        end
    end

    assign t_out    = t_out_s;
    assign busy     = busy_r;
    assign done     = done_r;
    assign tc_pulse = tc_r;

endmodule

// File: tb/tb_sync_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_counter_ctrl
//   Drives sync_counter_ctrl together with a behavioural T-FF bank. A reference
//   model tracks the counter as a plain number (+1 / -1 / reload / load) and the
//   controller mode, and every cycle the bench compares the toggle enables, the
//   bank value and the status outputs against it. Directed scenarios come first,
//   followed by randomized commands.
// -----------------------------------------------------------------------------
module tb_sync_counter_ctrl;

    localparam int WIDTH    = 4;
    localparam int PRESCALE = 4;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_DONE = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic             auto_reload;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q = '0;
    logic [WIDTH-1:0] t_out;
    logic             busy;
    logic             done;
    logic             tc_pulse;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int               m_state = M_IDLE;
    bit               m_dir = 1'b1;
    bit               m_reload = 1'b0;
    logic [WIDTH-1:0] m_q = '0;
    bit               m_tc = 1'b0;
    int               m_phase = 0;

    sync_counter_ctrl #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .load        (load),
        .load_val    (load_val),
        .dir         (dir),
        .auto_reload (auto_reload),
        .limit       (limit),
        .q_in        (q),
        .t_out       (t_out),
        .busy        (busy),
        .done        (done),
        .tc_pulse    (tc_pulse)
    );

    always #5 clk = ~clk;

    // The T flip-flop bank being sequenced.
    always @(posedge clk) q <= q ^ t_out;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle with the currently driven inputs; called just after a negedge.
    task automatic tick();
        logic [WIDTH-1:0] nq;
        int               ns;
        bit               ntc;
        bit               stepping;
        bit               at_term;
        #1;
        nq  = m_q;
        ns  = m_state;
        ntc = 1'b0;
        if (rst) begin
            ns       = M_IDLE;
            m_dir    = 1'b1;
            m_reload = 1'b0;
            m_phase  = 0;
        end else if (load) begin
            nq      = load_val;
            m_phase = 0;
            if (m_state == M_DONE) ns = M_IDLE;
        end else if (stop) begin
            if (m_state == M_RUN) ns = M_HOLD;
            else if (m_state == M_HOLD || m_state == M_DONE) ns = M_IDLE;
        end else if (start && m_state != M_RUN) begin
            ns       = M_RUN;
            m_dir    = dir;
            m_reload = auto_reload;
            m_phase  = 0;
        end else if (m_state == M_RUN) begin
`ifdef SYNC_CNT_PRESCALE_EN
            stepping = (m_phase == PRESCALE - 1);
            m_phase  = (m_phase + 1) % PRESCALE;
`else
            stepping = 1'b1;
`endif
            if (stepping) begin
                at_term = m_dir ? (m_q == limit) : (m_q == 0);
                if (at_term) begin
                    ntc = 1'b1;
                    if (m_reload) nq = m_dir ? '0 : limit;
                    else ns = M_DONE;
                end else if (m_dir) begin
                    nq = m_q + 4'd1;
                end else begin
                    nq = m_q - 4'd1;
                end
            end
        end
        check_val("t_out", t_out, m_q ^ nq);
        @(posedge clk);
        @(negedge clk);
        m_q     = nq;
        m_state = ns;
        m_tc    = ntc;
        check_val("q", q, m_q);
        check_val("busy", busy, (m_state == M_RUN || m_state == M_HOLD));
        check_val("done", done, (m_state == M_DONE));
        check_val("tc_pulse", tc_pulse, m_tc);
    endtask

    task automatic clear_cmds();
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        load  = 1'b0;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load     = 1'b1;
        load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start(input bit d, input bit ar, input logic [WIDTH-1:0] lim);
        start       = 1'b1;
        dir         = d;
        auto_reload = ar;
        limit       = lim;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin : main
        logic [WIDTH-1:0] seq3 [6];
        int               r;
        seq3[0] = 4'd0; seq3[1] = 4'd3; seq3[2] = 4'd2;
        seq3[3] = 4'd1; seq3[4] = 4'd0; seq3[5] = 4'd3;

        clear_cmds();
        load_val    = '0;
        dir         = 1'b1;
        auto_reload = 1'b0;
        limit       = '0;
        @(negedge clk);

        // Reset held for two cycles
        rst = 1'b1;
        tick();
        tick();
        check_val("rst_t_out", t_out, 4'h0);
        rst = 1'b0;

        // One-shot up count 0..5
        do_load(4'h0);
        do_start(1'b1, 1'b0, 4'd5);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val("up_seq", q, i);
        end
        tick();
        check_val("up_tc", tc_pulse, 1'b1);
        tick();
        check_val("up_done", done, 1'b1);
        check_val("up_hold5", q, 4'd5);
        check_val("up_tc_once", tc_pulse, 1'b0);

        // Down auto-reload from 1 with limit 3
        do_load(4'h1);
        do_start(1'b0, 1'b1, 4'd3);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("down_seq", q, seq3[i]);
        end

        // Load while running: 3 -> A, counting continues up
        do_stop();
        do_stop();
        do_load(4'h3);
        do_start(1'b1, 1'b0, 4'hF);
        load     = 1'b1;
        load_val = 4'hA;
        #1;
        check_val("load_t_out", t_out, 4'h9);
        tick();
        load = 1'b0;
        check_val("load_q", q, 4'hA);
        tick();
        check_val("load_cont", q, 4'hB);

        // Stop/hold/resume
        do_stop();
        do_stop();
        do_load(4'h1);
        do_start(1'b1, 1'b0, 4'hF);
        tick();
        do_stop();
        for (int i = 0; i < 5; i++) tick();
        check_val("hold_q", q, 4'd2);
        check_val("hold_busy", busy, 1'b1);
        do_start(1'b1, 1'b0, 4'hF);
        tick();
        check_val("resume_q", q, 4'd3);
        do_stop();
        do_stop();
        check_val("idle_busy", busy, 1'b0);

        // Up with limit 0 and auto-reload: terminal on every step at zero
        do_load(4'h0);
        do_start(1'b1, 1'b1, 4'd0);
        tick();
        tick();
        check_val("lim0_tc", tc_pulse, 1'b1);

        // Randomized commands
        for (int c = 0; c < 600; c++) begin
            r           = $urandom_range(0, 99);
            rst         = (r < 3);
            load        = (r >= 3 && r < 11);
            stop        = (r >= 11 && r < 19) || ($urandom_range(0, 19) == 0);
            start       = (r >= 19 && r < 34) || ($urandom_range(0, 19) == 0);
            load_val    = WIDTH'($urandom);
            dir         = 1'($urandom);
            auto_reload = 1'($urandom);
            if ($urandom_range(0, 9) == 0) limit = WIDTH'($urandom);
            tick();
        end
        clear_cmds();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
